// File: rtl/d_mem_arbiter.sv
// Shares the single data-memory/MMIO port between the core load/store path and the fabric agent.
// The core has priority, and a starvation counter forces a fabric grant.
module d_mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic        clock,
  input  logic        rst,
  // core load/store path
  input  logic        core_req_valid,
  input  logic        core_wren,
  input  logic [31:0] core_address,
  input  logic [3:0]  core_byteena,
  input  logic [31:0] core_data,
  output logic        core_stall,
  output logic        core_rd_valid,
  output logic [31:0] core_q,
  // fabric agent
  input  logic        fab_req_valid,
  output logic        fab_req_ready,
  input  logic        fab_wren,
  input  logic [31:0] fab_address,
  input  logic [3:0]  fab_byteena,
  input  logic [31:0] fab_data,
  output logic        fab_rsp_valid,
  output logic [31:0] fab_rsp_q,
  // d_mem_wrap side
  output logic [31:0] mem_address,
  output logic [3:0]  mem_byteena,
  output logic [31:0] mem_data,
  output logic        mem_rden,
  output logic        mem_wren,
  input  logic [31:0] mem_q
);

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnCore = 2'd1,
    OwnFab  = 2'd2
  } owner_e;

  localparam logic [CNT_W-1:0] StarveMax = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  owner_e           rd_owner_q, rd_owner_d;

  logic force_gnt;
  logic fab_gnt;
  logic core_gnt;

  // Grants are masked while reset is high so nothing reaches memory.
  always_comb begin
    force_gnt = !rst && fab_req_valid && (starve_cnt_q == StarveMax);
    fab_gnt   = force_gnt || (!rst && fab_req_valid && !core_req_valid);
    core_gnt  = !rst && core_req_valid && !fab_gnt;
  end

  always_comb begin
    fab_req_ready = fab_gnt;
    core_stall    = !rst && core_req_valid && !core_gnt;
  end

  always_comb begin
    mem_address = '0;
    mem_byteena = '0;
    mem_data    = '0;
    mem_rden    = 1'b0;
    mem_wren    = 1'b0;
    if (fab_gnt) begin
      mem_address = fab_address;
      mem_byteena = fab_byteena;
      mem_data    = fab_data;
      mem_rden    = !fab_wren;
      mem_wren    = fab_wren;
    end else if (core_gnt) begin
      mem_address = core_address;
      mem_byteena = core_byteena;
      mem_data    = core_data;
      mem_rden    = !core_wren;
      mem_wren    = core_wren;
    end
  end

  always_comb begin
    if (fab_gnt || !fab_req_valid) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q == StarveMax) begin
      starve_cnt_d = starve_cnt_q;
    end else begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  // Owner of the read issued this cycle; its data arrives on mem_q next cycle.
  always_comb begin
    rd_owner_d = OwnNone;
    if (fab_gnt && !fab_wren) begin
      rd_owner_d = OwnFab;
    end else if (core_gnt && !core_wren) begin
      rd_owner_d = OwnCore;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
      rd_owner_q   <= OwnNone;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  always_comb begin
    core_rd_valid = (rd_owner_q == OwnCore);
    fab_rsp_valid = (rd_owner_q == OwnFab);
    core_q        = core_rd_valid ? mem_q : 32'h0;
    fab_rsp_q     = fab_rsp_valid ? mem_q : 32'h0;
  end

endmodule
